// File: rtl/prio_enc_pkg.sv
// Shared constants and width helpers for the pipelined priority encoder
// and its selector.
package prio_enc_pkg;

    localparam int CODE_NONE = 0;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Code must represent 0 (none) plus indices 1..n.
    function automatic int code_width(input int n);
        return clog2(n + 1);
    endfunction

endpackage

// File: rtl/prio_encoder_pipe_sel.sv
// prio_sel: combinational highest-set-index selector over a [N:1] vector.
// Produces the index (0 when empty) and the matching one-hot.
module prio_sel
    import prio_enc_pkg::*;
#(
    parameter int N = 4,
    localparam int W = code_width(N)
) (
    input  logic [N:1]   vec,
    output logic [W-1:0] idx,
    output logic [N:1]   sel_onehot
);

    logic [W-1:0] idx_s;
    logic [N:1]   oh_s;

    // Ascending scan lets the highest set bit overwrite lower ones.
    always_comb begin
        idx_s = W'(CODE_NONE);
        oh_s  = {N{1'b0}};
        for (int i = 1; i <= N; i++) begin
            idx_s = vec[i] ? W'(i) : idx_s;
        end
        for (int i = 1; i <= N; i++) begin
            oh_s[i] = (idx_s == W'(i));
        end
    end

    assign idx        = idx_s;
    assign sel_onehot = oh_s;

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered N-input priority encoder with pending buffer and valid/ready output.
// Define PRIO_ENC_PIPE_RR_EN to switch from fixed to rotating priority.
module prio_encoder_pipe
    import prio_enc_pkg::*;
#(
    parameter int N = 4,
    localparam int W = code_width(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N:1]   req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] code,
    output logic [N:1]   onehot,
    output logic [N:1]   pending,
    output logic         busy
);

    logic [N:1]   pending_r;
    logic         valid_r;
    logic [W-1:0] code_r;
    logic [N:1]   onehot_r;
    logic         busy_r;

    logic         slot_free_s;
    logic         load_s;
    logic [W-1:0] sel_code_s;
    logic [N:1]   sel_oh_s;
    logic [N:1]   load_mask_s;
    logic [N:1]   pending_nxt_s;
    logic         valid_nxt_s;
    logic [W-1:0] code_nxt_s;
    logic [N:1]   onehot_nxt_s;

`ifdef PRIO_ENC_PIPE_RR_EN
    logic [W-1:0] last_r;
    logic [N:1]   rr_mask_s;
    logic [N:1]   masked_s;
    logic [W-1:0] m_code_s;
    logic [N:1]   m_oh_s;
    logic [W-1:0] u_code_s;
    logic [N:1]   u_oh_s;

    // Indices strictly below the last loaded one are searched first.
    always_comb begin
        rr_mask_s = {N{1'b0}};
        for (int i = 1; i <= N; i++) begin
            rr_mask_s[i] = (W'(i) < last_r);
        end
    end

    assign masked_s = pending_r & rr_mask_s;

    prio_sel #(.N(N)) u_sel_masked (
        .vec        (masked_s),
        .idx        (m_code_s),
        .sel_onehot (m_oh_s)
    );

    prio_sel #(.N(N)) u_sel_full (
        .vec        (pending_r),
        .idx        (u_code_s),
        .sel_onehot (u_oh_s)
    );

    // Wrap to the unmasked search once nothing is left below the pointer.
    always_comb begin
        if (m_code_s != W'(CODE_NONE)) begin
            sel_code_s = m_code_s;
            sel_oh_s   = m_oh_s;
        end else begin
            sel_code_s = u_code_s;
            sel_oh_s   = u_oh_s;
        end
    end

    // Rotation pointer tracks the last index moved into the output slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= W'(1);
        end else if (load_s) begin
            last_r <= sel_code_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    prio_sel #(.N(N)) u_sel (
        .vec        (pending_r),
        .idx        (sel_code_s),
        .sel_onehot (sel_oh_s)
    );
`endif

    assign slot_free_s = ~valid_r | out_ready;
    assign load_s      = slot_free_s & (|pending_r);
    assign load_mask_s = load_s ? sel_oh_s : {N{1'b0}};

    // A request arriving on the clearing edge re-arms the bit.
    assign pending_nxt_s = (pending_r & ~load_mask_s) | req;

    // Output slot: load on free slot, empty when nothing pending, else hold.
    always_comb begin
        valid_nxt_s  = valid_r;
        code_nxt_s   = code_r;
        onehot_nxt_s = onehot_r;
        if (slot_free_s) begin
            if (|pending_r) begin
                valid_nxt_s  = 1'b1;
                code_nxt_s   = sel_code_s;
                onehot_nxt_s = sel_oh_s;
            end else begin
                valid_nxt_s  = 1'b0;
                code_nxt_s   = W'(CODE_NONE);
                onehot_nxt_s = {N{1'b0}};
            end
        end else begin
            valid_nxt_s  = valid_r;
            code_nxt_s   = code_r;
            onehot_nxt_s = onehot_r;
        end
    end

    // State and output registers; busy is registered from next-state values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= {N{1'b0}};
            valid_r   <= 1'b0;
            code_r    <= W'(CODE_NONE);
            onehot_r  <= {N{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            valid_r   <= valid_nxt_s;
            code_r    <= code_nxt_s;
            onehot_r  <= onehot_nxt_s;
            busy_r    <= valid_nxt_s | (|pending_nxt_s);
        end
    end

    assign out_valid = valid_r;
    assign code      = code_r;
    assign onehot    = onehot_r;
    assign pending   = pending_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Scoreboard bench for prio_encoder_pipe (N=4); expectations pushed by stimulus,
// popped by a negedge monitor on every accepted transfer.
module tb_prio_encoder_pipe;

    logic       clk;
    logic       reset_n;
    logic [4:1] req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] code;
    logic [4:1] onehot;
    logic [4:1] pending;
    logic       busy;

    int total;
    int bad;
    int exp_q[$];

    prio_encoder_pipe #(.N(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code      (code),
        .onehot    (onehot),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each transfer, checks idle/busy invariants otherwise.
    initial begin
        int e;
        logic [4:1] e_oh;
        forever begin
            @(negedge clk);
            check("busy_eq", int'(busy), int'(out_valid | (|pending)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", int'(code), 0);
                end else begin
                    e = exp_q.pop_front();
                    e_oh = 4'b0000;
                    e_oh[e] = 1'b1;
                    check("xfer_code", int'(code), e);
                    check("xfer_onehot", int'(onehot), int'(e_oh));
                end
            end else if (!out_valid) begin
                check("idle_code", int'(code), 0);
                check("idle_onehot", int'(onehot), 0);
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b1;

        // Reset with req toggling: everything stays clear.
        for (int i = 0; i < 4; i++) begin
            req = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            tick();
            check("rst_valid", int'(out_valid), 0);
            check("rst_code", int'(code), 0);
            check("rst_onehot", int'(onehot), 0);
            check("rst_pending", int'(pending), 0);
            check("rst_busy", int'(busy), 0);
        end
        req = 4'b0000;
        reset_n = 1'b1;
        tick();

        // Fixed order: 0110 -> 3 then 2 then empty.
        req = 4'b0110;
        exp_q.push_back(3);
        exp_q.push_back(2);
        tick();
        req = 4'b0000;
        check("fo_pending", int'(pending), 6);
        tick();
        check("fo_code3", int'(code), 3);
        tick();
        check("fo_code2", int'(code), 2);
        tick();
        check("fo_empty_valid", int'(out_valid), 0);
        check("fo_empty_code", int'(code), 0);

        // Backpressure: 4 held while 1 waits pending.
        out_ready = 1'b0;
        req = 4'b1001;
        exp_q.push_back(4);
        exp_q.push_back(1);
        tick();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_code_hold", int'(code), 4);
            check("bp_onehot_hold", int'(onehot), 8);
            check("bp_pending", int'(pending), 1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_code1", int'(code), 1);
        check("bp_pending_clr", int'(pending), 0);
        tick();
        check("bp_empty", int'(out_valid), 0);

        // Same-edge re-arm of bit 4.
        req = 4'b1000;
        exp_q.push_back(4);
        exp_q.push_back(4);
        tick();
        tick();
        req = 4'b0000;
        check("rearm_pending", int'(pending), 8);
        check("rearm_code_a", int'(code), 4);
        tick();
        check("rearm_code_b", int'(code), 4);
        check("rearm_valid_b", int'(out_valid), 1);
        tick();
        check("rearm_empty", int'(out_valid), 0);

        // Mid-stream reset with a presented code and pending 0011.
        out_ready = 1'b0;
        req = 4'b1000;
        tick();
        req = 4'b0011;
        tick();
        req = 4'b0000;
        check("mr_pre_pending", int'(pending), 3);
        check("mr_pre_valid", int'(out_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_valid", int'(out_valid), 0);
        check("mr_code", int'(code), 0);
        check("mr_onehot", int'(onehot), 0);
        check("mr_pending", int'(pending), 0);
        check("mr_busy", int'(busy), 0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_post_valid", int'(out_valid), 0);
        end

        // Continuous 1111 with ready high: five transfers observed.
`ifdef PRIO_ENC_PIPE_RR_EN
        exp_q.push_back(4);
        exp_q.push_back(3);
        exp_q.push_back(2);
        exp_q.push_back(1);
        exp_q.push_back(4);
`else
        for (int i = 0; i < 5; i++) exp_q.push_back(4);
`endif
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        req = 4'b0000;
        tick();
        reset_n = 1'b1;
        tick();

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
